// File: rtl/mesh_link_tx.sv
// Transmit endpoint of a mesh link: a 2-entry flit FIFO between a router output
// port and the link, plus per-link flit and stall counters.
module mesh_link_tx #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] dout,
    output logic             so,
    input  logic             ro,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] flit_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;
    logic             load_head;
    logic             head_from_tail;
    logic             load_tail;

    // Ready comes from registered state only, so there is no path from ro.
    assign tx_ready = (state != FULL) && !reset;
    assign push     = tx_valid && tx_ready;
    assign pop      = so && ro;

    // Occupancy state register; so mirrors "not empty" as a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            so    <= 1'b0;
        end else begin
            state <= state_nxt;
            so    <= (state_nxt != EMPTY);
        end
    end

    // Next-state and FIFO write controls.
    always_comb begin
        state_nxt      = state;
        load_head      = 1'b0;
        head_from_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_head      = 1'b1;
                    head_from_tail = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Head drives the link directly; tail only holds the second flit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
            tail <= '0;
        end else begin
            if (load_head) begin
                dout <= head_from_tail ? tail : tx_data;
            end
            if (load_tail) begin
                tail <= tx_data;
            end
        end
    end

    // Flit counter wraps; stall counter saturates; clear wins over both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_cnt  <= '0;
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            flit_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) begin
                flit_cnt <= flit_cnt + CNT_W'(1);
            end
            if (so && !ro && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mesh_link_tx.sv
// Directed self-checking bench for mesh_link_tx; counters run at a reduced
// width so wrap and saturation are reachable in a short run.
module tb_mesh_link_tx;

    localparam int unsigned W       = 64;
    localparam int unsigned CW      = 10;
    localparam int unsigned CNT_TOP = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [W-1:0]  dout;
    logic          so;
    logic          ro;
    logic          clr_cnt;
    logic [CW-1:0] flit_cnt;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    mesh_link_tx #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .dout      (dout),
        .so        (so),
        .ro        (ro),
        .clr_cnt   (clr_cnt),
        .flit_cnt  (flit_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_valid = 1'b0; tx_data = '0; ro = 1'b0; clr_cnt = 1'b0;
        #1;
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL rst_so: got %0b exp 0", so); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL rst_do: got %0h exp 0", dout); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b exp 0", tx_ready); end
        checks++; if (flit_cnt !== '0 || stall_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d exp 0/0", flit_cnt, stall_cnt); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b exp 1", tx_ready); end
        ro = 1'b1;
        tick(); tick();
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL rst_idle_so: got %0b exp 0", so); end
    endtask

    task automatic test_single();
        ro = 1'b1; tx_valid = 1'b1; tx_data = 64'hA5A5;
        tick();
        tx_valid = 1'b0;
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL single_so: got %0b exp 1", so); end
        checks++; if (dout !== 64'hA5A5) begin errors++; $display("FAIL single_do: got %0h exp a5a5", dout); end
        tick();
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL single_so_after_pop: got %0b exp 0", so); end
        checks++; if (flit_cnt !== CW'(1)) begin errors++; $display("FAIL single_flit_cnt: got %0d exp 1", flit_cnt); end
    endtask

    task automatic test_streaming();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        ro = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tx_valid = 1'b1; tx_data = W'(i + 1);
            tick();
            checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %0b exp 1", i, tx_ready); end
            checks++; if (so !== 1'b1 || dout !== W'(i + 1)) begin errors++; $display("FAIL stream_do[%0d]: got so=%0b do=%0h exp so=1 do=%0h", i, so, dout, i + 1); end
        end
        tx_valid = 1'b0;
        tick();
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL stream_drain_so: got %0b exp 0", so); end
        checks++; if (flit_cnt !== CW'(100)) begin errors++; $display("FAIL stream_flit_cnt: got %0d exp 100", flit_cnt); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL stream_stall_cnt: got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        ro = 1'b0;
        tx_valid = 1'b1; tx_data = W'(1);
        tick();
        checks++; if (tx_ready !== 1'b1 || dout !== W'(1)) begin errors++; $display("FAIL bp_first: got ready=%0b do=%0h exp ready=1 do=1", tx_ready, dout); end
        tx_data = W'(2);
        tick();
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %0b exp 0", tx_ready); end
        tx_data = W'(3);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (so !== 1'b1 || dout !== W'(1) || tx_ready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got so=%0b do=%0h ready=%0b exp 1/1/0", i, so, dout, tx_ready); end
        end
        checks++; if (stall_cnt !== CW'(5)) begin errors++; $display("FAIL bp_stall_cnt: got %0d exp 5", stall_cnt); end
        ro = 1'b1;
        tick();
        checks++; if (dout !== W'(2) || tx_ready !== 1'b1) begin errors++; $display("FAIL bp_out2: got do=%0h ready=%0b exp do=2 ready=1", dout, tx_ready); end
        tick();
        tx_valid = 1'b0;
        checks++; if (dout !== W'(3) || so !== 1'b1) begin errors++; $display("FAIL bp_out3: got do=%0h so=%0b exp do=3 so=1", dout, so); end
        tick();
        checks++; if (so !== 1'b0 || flit_cnt !== CW'(3) || stall_cnt !== CW'(5)) begin errors++; $display("FAIL bp_drain: got so=%0b flit=%0d stall=%0d exp 0/3/5", so, flit_cnt, stall_cnt); end
    endtask

    task automatic test_push_pop_one();
        ro = 1'b0; tx_valid = 1'b1; tx_data = 64'h10;
        tick();
        checks++; if (dout !== 64'h10) begin errors++; $display("FAIL pp_head: got %0h exp 10", dout); end
        ro = 1'b1; tx_data = 64'h20;
        tick();
        tx_valid = 1'b0;
        checks++; if (dout !== 64'h20 || so !== 1'b1 || tx_ready !== 1'b1) begin errors++; $display("FAIL pp_one: got do=%0h so=%0b ready=%0b exp 20/1/1", dout, so, tx_ready); end
        tick();
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL pp_drain: got %0b exp 0", so); end
    endtask

    task automatic test_counters();
        clr_cnt = 1'b1; ro = 1'b1; tick(); clr_cnt = 1'b0;
        for (int i = 0; i < int'(CNT_TOP); i++) begin
            tx_valid = 1'b1; tx_data = W'(i);
            tick();
        end
        tx_valid = 1'b0;
        tick();
        checks++; if (flit_cnt !== CW'(CNT_TOP)) begin errors++; $display("FAIL cnt_flit_max: got %0d exp %0d", flit_cnt, CNT_TOP); end
        tx_valid = 1'b1; tick(); tx_valid = 1'b0; tick();
        checks++; if (flit_cnt !== '0) begin errors++; $display("FAIL cnt_flit_wrap: got %0d exp 0", flit_cnt); end
        ro = 1'b0; tx_valid = 1'b1; tx_data = 64'hBEEF;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < int'(CNT_TOP) - 1; i++) tick();
        checks++; if (stall_cnt !== CW'(CNT_TOP - 1)) begin errors++; $display("FAIL cnt_stall_pre: got %0d exp %0d", stall_cnt, CNT_TOP - 1); end
        for (int i = 0; i < 78; i++) tick();
        checks++; if (stall_cnt !== CW'(CNT_TOP)) begin errors++; $display("FAIL cnt_stall_sat: got %0d exp %0d", stall_cnt, CNT_TOP); end
        tx_valid = 1'b1; tx_data = 64'hCAFE;
        tick();
        tx_valid = 1'b0; ro = 1'b1;
        tick();
        checks++; if (flit_cnt !== CW'(1) || dout !== 64'hCAFE || stall_cnt !== CW'(CNT_TOP)) begin errors++; $display("FAIL cnt_pre_clr: got flit=%0d do=%0h stall=%0d exp 1/cafe/%0d", flit_cnt, dout, stall_cnt, CNT_TOP); end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++; if (flit_cnt !== '0 || stall_cnt !== '0 || so !== 1'b0) begin errors++; $display("FAIL cnt_clr_pop: got flit=%0d stall=%0d so=%0b exp 0/0/0", flit_cnt, stall_cnt, so); end
    endtask

    task automatic test_reset_mid();
        ro = 1'b0; tx_valid = 1'b1; tx_data = 64'h77;
        tick();
        tx_data = 64'h88;
        tick();
        tx_valid = 1'b0;
        checks++; if (stall_cnt !== CW'(1) || tx_ready !== 1'b0) begin errors++; $display("FAIL rmid_pre: got stall=%0d ready=%0b exp 1/0", stall_cnt, tx_ready); end
        #2 reset = 1'b1;
        #1;
        checks++; if (so !== 1'b0 || dout !== '0) begin errors++; $display("FAIL rmid_out: got so=%0b do=%0h exp 0/0", so, dout); end
        checks++; if (flit_cnt !== '0 || stall_cnt !== '0 || tx_ready !== 1'b0) begin errors++; $display("FAIL rmid_cnt: got flit=%0d stall=%0d ready=%0b exp 0/0/0", flit_cnt, stall_cnt, tx_ready); end
        @(negedge clk);
        reset = 1'b0; ro = 1'b1;
        #1;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %0b exp 1", tx_ready); end
        tick(); tick();
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL rmid_no_flit: got %0b exp 0", so); end
        tx_valid = 1'b1; tx_data = 64'h99;
        tick();
        tx_valid = 1'b0;
        checks++; if (so !== 1'b1 || dout !== 64'h99) begin errors++; $display("FAIL rmid_new: got so=%0b do=%0h exp 1/99", so, dout); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_push_pop_one();
        test_counters();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
